dcache_wb_bridge: RTL and testbench

Miss/eviction engine between `data_cache` and the Caravel Wishbone bus. It accepts one 128-bit line request at a time on the data cache's miss port and splits it into four 32-bit classic Wishbone single transfers. Fill data is assembled into a full line. It returns a one-cycle response pulse carrying either the line or a bus error.

---
 rtl/dcache_wb_bridge.sv | 231 +++++++++++++++++++++++
 tb/tb_dcache_wb_bridge.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_bridge.sv
// -----------------------------------------------------------------------------
// dcache_wb_bridge
//
// Miss/eviction engine between the data cache miss port and a classic
// Wishbone master port. One 128-bit line request is taken at a time and
// carried out as four ascending 32-bit single transfers. Fill beats are
// assembled into a line and returned with a one-cycle response pulse. The
// same pulse reports a bus error instead of data.
//
// Optional feature macro: DCACHE_WB_TIMEOUT_EN
//   When it is defined, a per-beat ack timeout of TIMEOUT_CYCLES stalled cycles
//   ends the line with a bus error. When it is undefined, the bridge waits
//   for ack or err indefinitely.
//
// Parameters
//   MEM_BASE        byte base added to every line address
//   TIMEOUT_CYCLES  per-beat timeout in cycles (1..255), timeout build only
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-low reset
//   req_valid_miss  one-cycle request pulse
//   req_info_miss   [148:129] line address, [128] is_store, [127:0] line data
//   rsp_valid_miss  one-cycle response pulse
//   rsp_bus_error   response carries an error
//   rsp_data_miss   filled line (zero for writes and errors)
//   req_overrun     sticky: a request arrived while a line was on the bus
//   wb_*_o          Wishbone master outputs, all registered
//   wb_dat_i/ack_i/err_i  Wishbone slave responses
// -----------------------------------------------------------------------------
module dcache_wb_bridge #(
  parameter logic [31:0] MEM_BASE       = 32'h3000_0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid_miss,
  input  logic [148:0] req_info_miss,
  output logic         rsp_valid_miss,
  output logic         rsp_bus_error,
  output logic [127:0] rsp_data_miss,
  output logic         req_overrun,
  output logic         wb_cyc_o,
  output logic         wb_stb_o,
  output logic         wb_we_o,
  output logic [3:0]   wb_sel_o,
  output logic [31:0]  wb_adr_o,
  output logic [31:0]  wb_dat_o,
  input  logic [31:0]  wb_dat_i,
  input  logic         wb_ack_i,
  input  logic         wb_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Control state
  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic          err_q, err_d;
  logic          overrun_q, overrun_d;

  // Line context (no reset needed: always loaded on acceptance)
  logic [19:0]   addr_q, addr_d;
  logic          store_q, store_d;
  logic [127:0]  line_q, line_d;

  // Registered outputs
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dout_q, dout_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [127:0]  rsp_data_q, rsp_data_d;

  logic          accept;
  logic          tmo_hit;
  logic          bus_fail;

`ifdef DCACHE_WB_TIMEOUT_EN
  logic [7:0]    tmo_q, tmo_d;

  // Fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES.
  assign tmo_hit = (state_q == BUS) && !wb_ack_i && !wb_err_i &&
                   (tmo_q == (TIMEOUT_CYCLES - 8'd1));
`else
  logic [7:0]    unused_tmo;

  assign unused_tmo = TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  // A timeout behaves exactly like a slave error.
  assign bus_fail = wb_err_i || tmo_hit;

  // Requests are taken in IDLE and RESP; RESP acceptance lets a fill follow
  // an eviction with a single idle bus cycle.
  assign accept = req_valid_miss && (state_q != BUS);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    err_d     = err_q;
    overrun_d = overrun_q;
    addr_d    = addr_q;
    store_d   = store_q;
    line_d    = line_q;
`ifdef DCACHE_WB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d = BUS;
          addr_d  = req_info_miss[148:129];
          store_d = req_info_miss[128];
          line_d  = req_info_miss[127:0];
          beat_d  = 2'd0;
          err_d   = 1'b0;
`ifdef DCACHE_WB_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end

      BUS: begin
        if (req_valid_miss) begin
          overrun_d = 1'b1;
        end
        if (bus_fail) begin
          // Err wins over a simultaneous ack; remaining beats are skipped.
          err_d   = 1'b1;
          state_d = RESP;
        end else if (wb_ack_i) begin
          if (!store_q) begin
            line_d[{beat_q, 5'd0} +: 32] = wb_dat_i;
          end
          if (beat_q == 2'd3) begin
            state_d = RESP;
          end else begin
            beat_d = beat_q + 2'd1;
          end
`ifdef DCACHE_WB_TIMEOUT_EN
          tmo_d = 8'd0;
`endif
        end else begin
`ifdef DCACHE_WB_TIMEOUT_EN
          tmo_d = tmo_q + 8'd1;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are computed from the next-cycle context so that every port
    // comes straight from a flop, yet shows the new beat one cycle after ack.
    cyc_d       = (state_d == BUS);
    we_d        = (state_d == BUS) && store_d;
    sel_d       = (state_d == BUS) ? 4'hF : 4'h0;
    adr_d       = (state_d == BUS) ? (MEM_BASE + {8'h00, addr_d, beat_d, 2'b00}) : 32'h0;
    dout_d      = ((state_d == BUS) && store_d) ? line_d[{beat_d, 5'd0} +: 32] : 32'h0;
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = (state_d == RESP) && err_d;
    rsp_data_d  = ((state_d == RESP) && !err_d && !store_d) ? line_d : 128'h0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      dout_q      <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 128'h0;
`ifdef DCACHE_WB_TIMEOUT_EN
      tmo_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
`ifdef DCACHE_WB_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    store_q <= store_d;
    line_q  <= line_d;
  end

  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = cyc_q;
  assign wb_we_o        = we_q;
  assign wb_sel_o       = sel_q;
  assign wb_adr_o       = adr_q;
  assign wb_dat_o       = dout_q;
  assign rsp_valid_miss = rsp_valid_q;
  assign rsp_bus_error  = rsp_err_q;
  assign rsp_data_miss  = rsp_data_q;
  assign req_overrun    = overrun_q;

endmodule

// File: tb/tb_dcache_wb_bridge.sv
module tb_dcache_wb_bridge;

  logic         clk;
  logic         rst_n;
  logic         req_valid_miss;
  logic [148:0] req_info_miss;
  logic         rsp_valid_miss;
  logic         rsp_bus_error;
  logic [127:0] rsp_data_miss;
  logic         req_overrun;
  logic         wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]   wb_sel_o;
  logic [31:0]  wb_adr_o, wb_dat_o;
  logic [31:0]  wb_dat_i;
  logic         wb_ack_i, wb_err_i;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  dcache_wb_bridge #(
    .MEM_BASE       (32'h3000_0000),
    .TIMEOUT_CYCLES (8'd4)
  ) dut (
    .clock          (clk),
    .reset          (rst_n),
    .req_valid_miss (req_valid_miss),
    .req_info_miss  (req_info_miss),
    .rsp_valid_miss (rsp_valid_miss),
    .rsp_bus_error  (rsp_bus_error),
    .rsp_data_miss  (rsp_data_miss),
    .req_overrun    (req_overrun),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_sel_o       (wb_sel_o),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line transaction: request fields, slave behaviour, expected result.
  typedef struct {
    logic         st;
    logic [19:0]  addr;
    logic [127:0] data;      // write data for evicts, slave read data for fills
    int           waits;     // wait states per beat
    int           err_beat;  // beat that gets err (4 = none)
    logic         both;      // ack raised together with err
    logic         exp_err;
    logic [127:0] exp_rsp;
    logic [31:0]  exp_adr0;  // address of beat 0
  } vec_t;

  vec_t vec [7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_req(input vec_t v);
    req_valid_miss = 1'b1;
    req_info_miss  = {v.addr, v.st, v.data};
    tick();
    req_valid_miss = 1'b0;
    req_info_miss  = '0;
  endtask

  // Acts as the slave for every beat, then checks the response cycle.
  task automatic serve(input vec_t v, input string tag);
    logic [31:0] ea;
    logic [31:0] ed;
    bit          ended;
    ended = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (!ended) begin
        ea = v.exp_adr0 + 32'(4 * b);
        ed = v.st ? v.data[32*b +: 32] : 32'h0;
        for (int w = 0; w <= v.waits; w++) begin
          chk($sformatf("%s b%0d cyc", tag, b), {wb_cyc_o, wb_stb_o}, 2'b11);
          chk($sformatf("%s b%0d adr", tag, b), wb_adr_o, ea);
          chk($sformatf("%s b%0d we/sel", tag, b), {wb_we_o, wb_sel_o}, {v.st, 4'hF});
          chk($sformatf("%s b%0d dat_o", tag, b), wb_dat_o, ed);
          if (w == v.waits) begin
            wb_dat_i = v.data[32*b +: 32];
            if (b == v.err_beat) begin
              wb_err_i = 1'b1;
              wb_ack_i = v.both;
              ended    = 1'b1;
            end else begin
              wb_ack_i = 1'b1;
            end
          end
          tick();
          wb_ack_i = 1'b0;
          wb_err_i = 1'b0;
          wb_dat_i = 32'h0;
        end
      end
    end
    chk($sformatf("%s rsp_valid", tag), rsp_valid_miss, 1'b1);
    chk($sformatf("%s rsp_err", tag), rsp_bus_error, v.exp_err);
    chk($sformatf("%s rsp_data", tag), rsp_data_miss, v.exp_rsp);
    chk($sformatf("%s cyc in resp", tag), {wb_cyc_o, wb_stb_o}, 2'b00);
  endtask

  task automatic chk_idle(input string tag);
    chk($sformatf("%s idle rsp", tag), {rsp_valid_miss, rsp_bus_error, rsp_data_miss}, 130'h0);
    chk($sformatf("%s idle wb", tag), {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 71'h0);
  endtask

  initial begin
    bit seen_rsp;
    vec_t ovr;

    vec[0] = '{st:1'b0, addr:20'h00012,
               data:{32'hA3, 32'hA2, 32'hA1, 32'hA0}, waits:0, err_beat:4, both:1'b0,
               exp_err:1'b0, exp_rsp:{32'hA3, 32'hA2, 32'hA1, 32'hA0}, exp_adr0:32'h3000_0120};
    vec[1] = '{st:1'b1, addr:20'h00001,
               data:128'h4444_4444_3333_3333_2222_2222_1111_1111, waits:2, err_beat:4, both:1'b0,
               exp_err:1'b0, exp_rsp:128'h0, exp_adr0:32'h3000_0010};
    vec[2] = '{st:1'b0, addr:20'h00003,
               data:128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0, waits:2, err_beat:4, both:1'b0,
               exp_err:1'b0, exp_rsp:128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0, exp_adr0:32'h3000_0030};
    vec[3] = '{st:1'b0, addr:20'h00040,
               data:128'h5555_5555_6666_6666_7777_7777_8888_8888, waits:1, err_beat:2, both:1'b0,
               exp_err:1'b1, exp_rsp:128'h0, exp_adr0:32'h3000_0400};
    vec[4] = '{st:1'b0, addr:20'h00050,
               data:128'h9999_9999_AAAA_AAAA_BBBB_BBBB_CCCC_CCCC, waits:0, err_beat:0, both:1'b1,
               exp_err:1'b1, exp_rsp:128'h0, exp_adr0:32'h3000_0500};
    vec[5] = '{st:1'b1, addr:20'hFFFFF,
               data:128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, waits:0, err_beat:1, both:1'b0,
               exp_err:1'b1, exp_rsp:128'h0, exp_adr0:32'h30FF_FFF0};
    vec[6] = '{st:1'b0, addr:20'hFFFFF,
               data:128'h8765_4321_FEDC_BA98_0011_2233_4455_6677, waits:0, err_beat:4, both:1'b0,
               exp_err:1'b0, exp_rsp:128'h8765_4321_FEDC_BA98_0011_2233_4455_6677, exp_adr0:32'h30FF_FFF0};

    rst_n          = 1'b0;
    req_valid_miss = 1'b0;
    req_info_miss  = '0;
    wb_dat_i       = 32'h0;
    wb_ack_i       = 1'b0;
    wb_err_i       = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset overrun", req_overrun, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_idle("post-reset");

    // Independent lines from the table.
    for (int i = 0; i < 7; i++) begin
      start_req(vec[i]);
      serve(vec[i], $sformatf("v%0d", i));
      tick();
      chk_idle($sformatf("v%0d", i));
    end
    chk("no overrun after table", req_overrun, 1'b0);

    // Evict then fill, fill pulsed in the eviction's response cycle.
    start_req(vec[1]);
    serve(vec[1], "b2b evict");
    start_req(vec[2]);
    serve(vec[2], "b2b fill");
    chk("b2b overrun", req_overrun, 1'b0);
    tick();
    chk_idle("b2b");

    // Request during BUS is dropped and sets the sticky overrun flag.
    ovr = vec[1];
    ovr.addr = 20'h00077;
    start_req(vec[0]);
    req_valid_miss = 1'b1;
    req_info_miss  = {ovr.addr, ovr.st, ovr.data};
    tick();
    req_valid_miss = 1'b0;
    req_info_miss  = '0;
    chk("overrun set", req_overrun, 1'b1);
    serve(vec[0], "ovr fill");
    tick();
    chk_idle("ovr");
    chk("overrun sticky", req_overrun, 1'b1);

    // Reset during beat 1 drops the bus at once and gives no response.
    start_req(vec[0]);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hA0;
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    chk("rst beat1 adr", wb_adr_o, 32'h3000_0124);
    rst_n = 1'b0;
    #1;
    chk_idle("mid-line reset");
    chk("reset clears overrun", req_overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("after reset");
    start_req(vec[0]);
    serve(vec[0], "fill after reset");
    tick();
    chk_idle("fill after reset");

    // Silent slave.
    start_req(vec[0]);
`ifdef DCACHE_WB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo stall%0d cyc", i), {wb_cyc_o, wb_stb_o, rsp_valid_miss}, 3'b110);
      tick();
    end
    chk("tmo rsp", {rsp_valid_miss, rsp_bus_error, wb_cyc_o}, 3'b110);
    chk("tmo rsp_data", rsp_data_miss, 128'h0);
    tick();
    chk_idle("tmo");
`else
    seen_rsp = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rsp_valid_miss) seen_rsp = 1'b1;
    end
    chk("hang cyc", {wb_cyc_o, wb_stb_o}, 2'b11);
    chk("hang adr", wb_adr_o, 32'h3000_0120);
    chk("hang no rsp", seen_rsp, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("hang reset");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
